// File: rtl/tdm_demux_capture_pkg.sv
// rtl/tdm_demux_capture_pkg.sv - shared slot states, light patterns and dice bounds
package tdm_pkg;

  typedef enum logic {
    SLOT_DICE   = 1'b0,
    SLOT_LIGHTS = 1'b1
  } slot_e;

  localparam logic [2:0] LT_RED       = 3'b100;
  localparam logic [2:0] LT_RED_AMBER = 3'b110;
  localparam logic [2:0] LT_GREEN     = 3'b001;
  localparam logic [2:0] LT_AMBER     = 3'b010;

  localparam logic [2:0] DICE_MIN = 3'd1;
  localparam logic [2:0] DICE_MAX = 3'd6;

  function automatic logic dice_legal(input logic [2:0] v);
    return (v >= DICE_MIN) && (v <= DICE_MAX);
  endfunction

  function automatic logic light_legal(input logic [2:0] p);
    return (p == LT_RED) || (p == LT_RED_AMBER) || (p == LT_GREEN) || (p == LT_AMBER);
  endfunction

endpackage

// File: rtl/tdm_demux_capture_light_checker.sv
// rtl/tdm_demux_capture_light_checker.sv - light pattern legality check
// LIGHT_SEQ_CHECK_EN adds the red -> red+amber -> green -> amber order check.
module light_checker
  import tdm_pkg::*;
(
`ifdef LIGHT_SEQ_CHECK_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic       cap,
  input  logic [2:0] pat,
  output logic       err
);

  logic static_ok;
  assign static_ok = light_legal(pat);

`ifdef LIGHT_SEQ_CHECK_EN
  logic [2:0] ref_q;
  logic       ref_vld_q;
  logic       seq_bad;

  function automatic logic [2:0] next_of(input logic [2:0] p);
    case (p)
      LT_RED:       return LT_RED_AMBER;
      LT_RED_AMBER: return LT_GREEN;
      LT_GREEN:     return LT_AMBER;
      default:      return LT_RED;
    endcase
  endfunction

  assign seq_bad = ref_vld_q && static_ok && (pat != ref_q) && (pat != next_of(ref_q));
  assign err     = cap && (!static_ok || seq_bad);

  // Illegal patterns never become the reference for the next comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q     <= 3'b000;
      ref_vld_q <= 1'b0;
    end else if (cap && static_ok) begin
      ref_q     <= pat;
      ref_vld_q <= 1'b1;
    end
  end
`else
  assign err = cap && !static_ok;
`endif

endmodule

// File: rtl/tdm_demux_capture.sv
// rtl/tdm_demux_capture.sv - TDM select generator and dice/lights capture
// Optional LIGHT_SEQ_CHECK_EN enables the light sequence check.
module tdm_demux_capture
  import tdm_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] bus_in,
  output logic       sel,
  output logic [2:0] dice_q,
  output logic       dice_vld,
  output logic       dice_err,
  output logic       red,
  output logic       amber,
  output logic       green,
  output logic       lights_vld,
  output logic       lights_err,
  output logic [7:0] err_cnt
);

  slot_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  logic             cap_dice, cap_lights;
  logic             lt_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    last       = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    cap_dice   = 1'b0;
    cap_lights = 1'b0;
    if (last) begin
      cnt_d      = '0;
      state_d    = (state_q == SLOT_DICE) ? SLOT_LIGHTS : SLOT_DICE;
      cap_dice   = (state_q == SLOT_DICE);
      cap_lights = (state_q == SLOT_LIGHTS);
    end
  end

  light_checker u_light_checker (
`ifdef LIGHT_SEQ_CHECK_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .cap   (cap_lights),
    .pat   (bus_in),
    .err   (lt_err)
  );

  assign sel = (state_q == SLOT_LIGHTS);

  // Captures land one cycle after the sampling edge, together with the sel flip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SLOT_DICE;
      cnt_q      <= '0;
      dice_q     <= 3'b000;
      dice_vld   <= 1'b0;
      dice_err   <= 1'b0;
      {red, amber, green} <= 3'b000;
      lights_vld <= 1'b0;
      lights_err <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dice_vld   <= cap_dice;
      dice_err   <= cap_dice && !dice_legal(bus_in);
      lights_vld <= cap_lights;
      lights_err <= lt_err;
      if (cap_dice) dice_q <= bus_in;
      if (cap_lights) {red, amber, green} <= bus_in;
      if ((dice_err || lights_err) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
